// File: rtl/fir_tap_sequencer.sv
// Upstream control/data stage for a MAC pair. It holds the FIR delay line and the coefficients,
// and walks TAPS sample/coefficient pairs for each sample. Takes TAPS+3 cycles per sample; in_ready stays low while busy.
module fir_tap_sequencer #(
    parameter int W    = 16,
    parameter int TAPS = 8,
    parameter int AW   = 3
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [W-1:0]  in_sample,
    output logic          in_ready,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [W-1:0]  coef_data,
    output logic [W-1:0]  tap_sample,
    output logic [W-1:0]  tap_coef,
    output logic          acc_load,
    output logic          busy,
    output logic          out_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_K = AW'(TAPS - 1);

    state_t        state_q;
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] newest_q;
    logic [AW-1:0] k_q;
    logic          acc_load_q;
    logic          out_valid_q;
    logic          busy_q;
    logic          in_ready_q;

    logic [W-1:0]  smp_q  [TAPS];
    logic [W-1:0]  coef_q [TAPS];

    logic          accept_d;
    logic          coef_wr_d;
    logic [AW-1:0] rd_idx_d;

    // in_ready_q is high exactly in IDLE, so it gates both sample and coefficient writes.
    assign accept_d  = in_ready_q && in_valid;
    assign coef_wr_d = in_ready_q && coef_we;
    assign rd_idx_d  = newest_q - k_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            newest_q    <= '0;
            k_q         <= '0;
            acc_load_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        newest_q   <= wptr_q;
                        wptr_q     <= wptr_q + AW'(1);
                        state_q    <= PRIME;
                        acc_load_q <= 1'b1;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b0;
                    end
                end
                PRIME: begin
                    k_q        <= '0;
                    acc_load_q <= 1'b0;
                    state_q    <= RUN;
                end
                RUN: begin
                    if (k_q == LAST_K) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        k_q <= k_q + AW'(1);
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    acc_load_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    // Delay line and coefficient file; the write pointer wraps naturally at AW bits.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < TAPS; i++) begin
                smp_q[i]  <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            if (accept_d) begin
                smp_q[wptr_q] <= in_sample;
            end
            if (coef_wr_d) begin
                coef_q[coef_addr] <= coef_data;
            end
        end
    end

    assign tap_sample = (state_q == RUN) ? smp_q[rd_idx_d] : '0;
    assign tap_coef   = (state_q == RUN) ? coef_q[k_q]     : '0;
    assign acc_load   = acc_load_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign in_ready   = in_ready_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: a downstream accumulator stand-in plus a queue-based reference filter.
module tb_fir_tap_sequencer;
    localparam int W    = 16;
    localparam int TAPS = 8;
    localparam int AW   = 3;

    logic          clk = 1'b0;
    logic          clear = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_sample = '0;
    logic          in_ready;
    logic          coef_we = 1'b0;
    logic [AW-1:0] coef_addr = '0;
    logic [W-1:0]  coef_data = '0;
    logic [W-1:0]  tap_sample;
    logic [W-1:0]  tap_coef;
    logic          acc_load;
    logic          busy;
    logic          out_valid;

    fir_tap_sequencer #(.W(W), .TAPS(TAPS), .AW(AW)) dut (
        .clk(clk), .clear(clear), .in_valid(in_valid), .in_sample(in_sample),
        .in_ready(in_ready), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .tap_sample(tap_sample), .tap_coef(tap_coef),
        .acc_load(acc_load), .busy(busy), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference filter state: coefficient table and history, newest sample first.
    logic [W-1:0]  m_coef [TAPS];
    logic [W-1:0]  m_hist [$];
    logic [31:0]   exp_q  [$];
    logic [31:0]   obs_y  [$];

    // Downstream accumulator stand-in: products captured mid-cycle, summed on the edge.
    logic [31:0] acc = '0;
    logic        p_load = 1'b0;
    logic [31:0] p_prod = '0;

    always @(negedge clk) begin
        p_load = acc_load;
        p_prod = 32'(tap_sample) * 32'(tap_coef);
    end

    always @(posedge clk) begin
        if (clear || p_load) acc <= '0;
        else                 acc <= acc + p_prod;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT flags a finished result.
    logic [31:0] mon_e;
    always @(negedge clk) begin
        if (!clear) begin
            if (out_valid) begin
                obs_y.push_back(acc);
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 64'(out_valid), 64'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("y", 64'(acc), 64'(mon_e));
                end
            end
            if (!busy) check("idle_taps", {32'd0, tap_sample, tap_coef}, 64'd0);
        end
    end

    function automatic logic [31:0] model_y();
        logic [31:0] s = '0;
        for (int j = 0; j < TAPS; j++)
            if (j < m_hist.size()) s += 32'(m_hist[j]) * 32'(m_coef[j]);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_hist.delete();
        exp_q.delete();
        obs_y.delete();
        for (int i = 0; i < TAPS; i++) m_coef[i] = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) check("wait_in_ready_timeout", 64'(in_ready), 64'(1));
    endtask

    // Offers one sample (optionally with a coefficient write in the same cycle).
    task automatic accept(input logic [W-1:0] x, input logic we,
                          input logic [AW-1:0] a, input logic [W-1:0] d);
        wait_idle();
        in_valid = 1'b1; in_sample = x;
        coef_we = we; coef_addr = a; coef_data = d;
        tick();
        in_valid = 1'b0; coef_we = 1'b0;
        if (we) m_coef[a] = d;
        m_hist.push_front(x);
        if (m_hist.size() > TAPS) void'(m_hist.pop_back());
        exp_q.push_back(model_y());
    endtask

    task automatic send(input logic [W-1:0] x);
        accept(x, 1'b0, '0, '0);
    endtask

    task automatic write_coef(input logic [AW-1:0] a, input logic [W-1:0] d);
        wait_idle();
        coef_we = 1'b1; coef_addr = a; coef_data = d;
        tick();
        coef_we = 1'b0;
        m_coef[a] = d;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            tick();
            n++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] xr;
        int nobs;

        // Reset state
        do_reset();
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_acc_load", 64'(acc_load), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_taps", {32'd0, tap_sample, tap_coef}, 64'd0);

        // Impulse response with h[k]=k+1
        for (int k = 0; k < TAPS; k++) write_coef(AW'(k), W'(k + 1));
        send(16'd1);
        for (int i = 0; i < TAPS; i++) send(16'd0);
        drain();
        check("impulse_count", 64'(obs_y.size()), 64'(TAPS + 1));
        for (int i = 0; i <= TAPS && i < obs_y.size(); i++)
            check("impulse_y", 64'(obs_y[i]), (i < TAPS) ? 64'(i + 1) : 64'd0);

        // Cycle-accurate timing of one pass, including each tap pair
        accept(16'd3, 1'b0, '0, '0);
        check("t_prime_load", 64'(acc_load), 64'(1));
        check("t_prime_rdy", 64'(in_ready), 64'(0));
        check("t_prime_busy", 64'(busy), 64'(1));
        check("t_prime_taps", {32'd0, tap_sample, tap_coef}, 64'd0);
        for (int i = 0; i < TAPS; i++) begin
            tick();
            check("t_run_load", 64'(acc_load), 64'(0));
            check("t_run_rdy", 64'(in_ready), 64'(0));
            check("t_run_ov", 64'(out_valid), 64'(0));
            check("t_run_coef", 64'(tap_coef), 64'(m_coef[i]));
            check("t_run_smp", 64'(tap_sample), 64'(m_hist[i]));
        end
        tick();
        check("t_done_ov", 64'(out_valid), 64'(1));
        check("t_done_rdy", 64'(in_ready), 64'(0));
        check("t_done_taps", {32'd0, tap_sample, tap_coef}, 64'd0);
        tick();
        check("t_idle_ov", 64'(out_valid), 64'(0));
        check("t_idle_rdy", 64'(in_ready), 64'(1));
        drain();

        // Busy ignore: sample and coefficient write offered during RUN are dropped
        nobs = obs_y.size();
        send(16'd7);
        tick(); tick(); tick();
        in_valid = 1'b1; in_sample = 16'd99;
        coef_we = 1'b1; coef_addr = '0; coef_data = 16'd50;
        tick();
        in_valid = 1'b0; coef_we = 1'b0;
        drain();
        send(16'd2);
        drain();
        check("busy_ignore_passes", 64'(obs_y.size() - nobs), 64'(2));

        // Wrap-around with all h=1
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(AW'(k), 16'd1);
        for (int x = 1; x <= 12; x++) send(W'(x));
        drain();
        check("wrap_y68", 64'(obs_y[obs_y.size() - 1]), 64'd68);

        // Reset in the middle of RUN (k=3)
        send(16'd9);
        tick(); tick(); tick(); tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_hist.delete(); exp_q.delete(); obs_y.delete();
        for (int i = 0; i < TAPS; i++) m_coef[i] = '0;
        check("midrst_rdy", 64'(in_ready), 64'(1));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_ov", 64'(out_valid), 64'(0));
        check("midrst_taps", {32'd0, tap_sample, tap_coef}, 64'd0);
        send(16'd5);
        drain();
        check("midrst_y0", 64'(obs_y.size() == 1 ? obs_y[0] : 32'hDEAD), 64'd0);

        // Full-scale: accumulator wraps modulo 2^32
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(AW'(k), 16'hFFFF);
        for (int i = 0; i < TAPS - 1; i++) send(16'hFFFF);
        send(16'hFFFF);
        tick();
        for (int i = 0; i < TAPS; i++) begin
            check("fs_taps", {32'd0, tap_sample, tap_coef}, 64'hFFFF_FFFF);
            tick();
        end
        drain();
        check("fs_y", 64'(obs_y[obs_y.size() - 1]), 64'hFFF0_0008);

        // Randomized traffic with coefficient updates, including same-cycle writes
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(AW'(k), W'($urandom));
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) write_coef(AW'($urandom), W'($urandom));
            xr = W'($urandom);
            if ($urandom_range(0, 2) == 0) accept(xr, 1'b1, AW'($urandom), W'($urandom));
            else                           send(xr);
            repeat ($urandom_range(0, 3)) tick();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
